// File: rtl/config_loader_if.sv
// Handshake and chain-side signals of config_loader.
// The crc_out signal exists only when CFG_LOADER_CRC_EN is defined.
interface config_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              config_in;
  logic              config_clk;
  logic              config_en;
  logic              busy;
  logic              done;
`ifdef CFG_LOADER_CRC_EN
  logic [7:0]        crc_out;
`endif

  modport master (
    output start, word_in, word_valid,
    input  word_ready, config_in, config_clk, config_en, busy, done
`ifdef CFG_LOADER_CRC_EN
    , input crc_out
`endif
  );

  modport slave (
    input  start, word_in, word_valid,
    output word_ready, config_in, config_clk, config_en, busy, done
`ifdef CFG_LOADER_CRC_EN
    , output crc_out
`endif
  );
endinterface

// File: rtl/config_loader.sv
// Serialises a word-wide configuration bitstream onto a CLB shift chain (bit 0 of each word first).
// Optional macro CFG_LOADER_CRC_EN adds a bit-serial CRC-8 of the shifted bits on bus.crc_out.
module config_loader #(
  parameter int CHAIN_LEN = 267,
  parameter int WORD_W    = 8,
  parameter int CLK_DIV   = 2
) (
  input logic           clk,
  input logic           rst_n,
  config_loader_if.slave bus
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [IDX_W-1:0]  r_bitIdx;
  logic [DIV_W-1:0]  r_div;
  logic [WORD_W-1:0] r_word;
  logic              r_wordReady;
  logic              r_configIn;
  logic              r_configClk;
  logic              r_configEn;
  logic              r_busy;
  logic              r_done;

  logic w_phaseEnd;
  logic w_startOk;

  assign w_phaseEnd = (r_div == LAST_DIV);
  assign w_startOk  = bus.start && ((r_state == IDLE) || (r_state == DONE));

  // Every output is a register so the chain never sees combinational glitches;
  // config_in is only ever updated together with a low (or falling) config_clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_bitIdx    <= '0;
      r_div       <= '0;
      r_word      <= '0;
      r_wordReady <= 1'b0;
      r_configIn  <= 1'b0;
      r_configClk <= 1'b0;
      r_configEn  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state     <= FETCH;
            r_bitCnt    <= '0;
            r_bitIdx    <= '0;
            r_div       <= '0;
            r_wordReady <= 1'b1;
            r_configIn  <= 1'b0;
            r_configClk <= 1'b0;
            r_configEn  <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end

        FETCH: begin
          if (bus.word_valid && r_wordReady) begin
            r_word      <= bus.word_in;
            r_configIn  <= bus.word_in[0];
            r_bitIdx    <= '0;
            r_div       <= '0;
            r_wordReady <= 1'b0;
            r_state     <= SHIFT_LO;
          end
        end

        SHIFT_LO: begin
          if (w_phaseEnd) begin
            r_div       <= '0;
            r_configClk <= 1'b1;
            r_state     <= SHIFT_HI;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (w_phaseEnd) begin
            r_div       <= '0;
            r_configClk <= 1'b0;
            r_bitCnt    <= r_bitCnt + 1'b1;
            // Chain length wins over word position, which drops unused upper bits of the last word.
            if (r_bitCnt == LAST_BIT) begin
              r_configIn <= 1'b0;
              r_configEn <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end else if (r_bitIdx == LAST_IDX) begin
              r_wordReady <= 1'b1;
              r_state     <= FETCH;
            end else begin
              r_bitIdx   <= r_bitIdx + 1'b1;
              r_configIn <= r_word[r_bitIdx + 1'b1];
              r_state    <= SHIFT_LO;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.word_ready = r_wordReady;
  assign bus.config_in  = r_configIn;
  assign bus.config_clk = r_configClk;
  assign bus.config_en  = r_configEn;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

`ifdef CFG_LOADER_CRC_EN
  logic [7:0] r_crc;

  // The CRC absorbs each bit at the moment the chain samples it (rising config_clk).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 8'h00;
    end else if (w_startOk) begin
      r_crc <= 8'h00;
    end else if ((r_state == SHIFT_LO) && w_phaseEnd) begin
      r_crc <= {r_crc[6:0], 1'b0} ^ ({8{r_crc[7] ^ r_configIn}} & 8'h07);
    end
  end

  assign bus.crc_out = r_crc;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: a long default chain plus a short CHAIN_LEN=8, CLK_DIV=1 instance.
// Expected bit order and CRC come from a reference model built from words and polynomial division.
`timescale 1ns/1ps
module tb_config_loader;

  localparam int W   = 8;
  localparam int L0  = 267;
  localparam int D0  = 2;
  localparam int NW0 = (L0 + W - 1) / W;
  localparam int L1  = 8;
  localparam int D1  = 1;

  logic clk = 1'b0;
  logic rst0_n;
  logic rst1_n;

  always #5 clk = ~clk;

  config_loader_if #(.WORD_W(W)) bus0 ();
  config_loader_if #(.WORD_W(W)) bus1 ();

  config_loader #(.CHAIN_LEN(L0), .WORD_W(W), .CLK_DIV(D0)) dut0 (
    .clk   (clk),
    .rst_n (rst0_n),
    .bus   (bus0)
  );

  config_loader #(.CHAIN_LEN(L1), .WORD_W(W), .CLK_DIV(D1)) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;

  bit   obs0[$];
  bit   obs1[$];
  int   edges0 = 0, edges1 = 0;
  int   shiftCyc0 = 0, shiftCyc1 = 0;
  int   viol0 = 0, viol1 = 0;
  logic prevClk0 = 1'b0, prevIn0 = 1'b0;
  logic prevClk1 = 1'b0, prevIn1 = 1'b0;

  logic [7:0] words0 [NW0];

  typedef struct {
    logic [7:0] word;
    logic [7:0] expSeq;
    logic [7:0] expCrc;
  } vec_t;

  vec_t vecs [4];

  // Chain-side monitors: rising edges, shifting cycles, and protocol violations
  // (config_in moving while config_clk is high, or FETCH not holding clk=0/en=1).
  always @(negedge clk) begin
    if (bus0.config_clk && !prevClk0) begin
      edges0 <= edges0 + 1;
      obs0.push_back(bus0.config_in);
    end
    if (bus0.config_en && !bus0.word_ready) shiftCyc0 <= shiftCyc0 + 1;
    if ((bus0.config_clk && (bus0.config_in != prevIn0)) ||
        (bus0.word_ready && (bus0.config_clk || !bus0.config_en)))
      viol0 <= viol0 + 1;
    prevClk0 <= bus0.config_clk;
    prevIn0  <= bus0.config_in;
  end

  always @(negedge clk) begin
    if (bus1.config_clk && !prevClk1) begin
      edges1 <= edges1 + 1;
      obs1.push_back(bus1.config_in);
    end
    if (bus1.config_en && !bus1.word_ready) shiftCyc1 <= shiftCyc1 + 1;
    if ((bus1.config_clk && (bus1.config_in != prevIn1)) ||
        (bus1.word_ready && (bus1.config_clk || !bus1.config_en)))
      viol1 <= viol1 + 1;
    prevClk1 <= bus1.config_clk;
    prevIn1  <= bus1.config_in;
  end

  // CRC-8 as the remainder of (message * x^8) mod x^8+x^2+x+1, first bit = highest degree.
  function automatic logic [7:0] crcRef(input bit msg[$]);
    logic [8:0] rem;
    bit b;
    rem = 9'h000;
    for (int i = 0; i < msg.size() + 8; i++) begin
      b   = (i < msg.size()) ? msg[i] : 1'b0;
      rem = {rem[7:0], b};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // One load on the short chain; optionally pulses start while config_clk is high.
  task automatic applyStimulus(input logic [7:0] w, input bit pulseStartHi,
                               input logic [7:0] expSeq, input logic [7:0] expCrc, input string tag);
    int baseEdges, baseObs, baseViol, baseShift, budget, bad;
    baseEdges = edges1;
    baseObs   = obs1.size();
    baseViol  = viol1;
    baseShift = shiftCyc1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    budget = 0;
    while (!bus1.word_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({tag, " fetchReady"}, 32'(bus1.word_ready), 1);
    bus1.word_in    = w;
    bus1.word_valid = 1'b1;
    @(negedge clk);
    bus1.word_valid = 1'b0;
    if (pulseStartHi) begin
      budget = 0;
      while (!bus1.config_clk && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      checkOutput({tag, " sawClkHigh"}, 32'(bus1.config_clk), 1);
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
    end
    budget = 0;
    while (!bus1.done && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({tag, " done"}, 32'(bus1.done), 1);
    checkOutput({tag, " edges"}, 32'(edges1 - baseEdges), L1);
    checkOutput({tag, " shiftCycles"}, 32'(shiftCyc1 - baseShift), 2 * D1 * L1);
    bad = 0;
    for (int k = 0; k < L1; k++)
      if ((baseObs + k >= obs1.size()) || (obs1[baseObs + k] != expSeq[k])) bad++;
    checkOutput({tag, " badBits"}, 32'(bad), 0);
    checkOutput({tag, " violations"}, 32'(viol1 - baseViol), 0);
    checkOutput({tag, " enBusyInClk"},
                32'({bus1.config_en, bus1.busy, bus1.config_in, bus1.config_clk, bus1.word_ready}), 0);
`ifdef CFG_LOADER_CRC_EN
    checkOutput({tag, " crc"}, 32'(bus1.crc_out), 32'(expCrc));
`endif
  endtask

  // One load on the default chain with upstream gaps; returns early once abortBit edges have passed.
  task automatic applyStimulusChain(input int gapMode, input int abortBit, input string tag, output bit aborted);
    int baseEdges, baseObs, baseViol, baseShift, budget, g, bad;
    bit expQ[$];
    aborted   = 1'b0;
    baseEdges = edges0;
    baseObs   = obs0.size();
    baseViol  = viol0;
    baseShift = shiftCyc0;
    for (int i = 0; i < NW0; i++) words0[i] = 8'($urandom());
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    for (int i = 0; i < NW0; i++) begin
      budget = 0;
      while (!bus0.word_ready && budget < 200) begin
        @(negedge clk);
        budget++;
        if (abortBit >= 0 && (edges0 - baseEdges) > abortBit) begin
          aborted = 1'b1;
          return;
        end
      end
      if (!bus0.word_ready) begin
        checkOutput({tag, " fetchTimeout"}, 0, 1);
        return;
      end
      g = (gapMode < 0) ? int'($urandom_range(0, 3)) : gapMode;
      repeat (g) @(negedge clk);
      bus0.word_in    = words0[i];
      bus0.word_valid = 1'b1;
      @(negedge clk);
      bus0.word_valid = 1'b0;
    end
    budget = 0;
    while (!bus0.done && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({tag, " done"}, 32'(bus0.done), 1);
    checkOutput({tag, " edges"}, 32'(edges0 - baseEdges), L0);
    checkOutput({tag, " shiftCycles"}, 32'(shiftCyc0 - baseShift), 2 * D0 * L0);
    for (int k = 0; k < L0; k++) expQ.push_back(words0[k / W][k % W]);
    bad = 0;
    for (int k = 0; k < L0; k++)
      if ((baseObs + k >= obs0.size()) || (obs0[baseObs + k] != expQ[k])) bad++;
    checkOutput({tag, " badBits"}, 32'(bad), 0);
    checkOutput({tag, " violations"}, 32'(viol0 - baseViol), 0);
    checkOutput({tag, " enBusyInClk"},
                32'({bus0.config_en, bus0.busy, bus0.config_in, bus0.config_clk, bus0.word_ready}), 0);
`ifdef CFG_LOADER_CRC_EN
    checkOutput({tag, " crc"}, 32'(bus0.crc_out), 32'(crcRef(expQ)));
`endif
    repeat (5) @(negedge clk);
    checkOutput({tag, " doneHeld"}, 32'({bus0.done, bus0.word_ready}), 32'b10);
  endtask

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] w;
    bit q[$];
    bit aborted;
    int edgesHold;

    vecs[0] = '{word: 8'h05, expSeq: 8'b0000_0101, expCrc: 8'h69};
    vecs[1] = '{word: 8'h01, expSeq: 8'b0000_0001, expCrc: 8'h89};
    vecs[2] = '{word: 8'h00, expSeq: 8'b0000_0000, expCrc: 8'h00};
    vecs[3] = '{word: 8'h80, expSeq: 8'b1000_0000, expCrc: 8'h07};

    bus0.start = 1'b0; bus0.word_valid = 1'b0; bus0.word_in = '0;
    bus1.start = 1'b0; bus1.word_valid = 1'b0; bus1.word_in = '0;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    #1;
    checkOutput("reset0 outputs",
                32'({bus0.word_ready, bus0.config_in, bus0.config_clk, bus0.config_en, bus0.busy, bus0.done}), 0);
    checkOutput("reset1 outputs",
                32'({bus1.word_ready, bus1.config_in, bus1.config_clk, bus1.config_en, bus1.busy, bus1.done}), 0);
`ifdef CFG_LOADER_CRC_EN
    checkOutput("reset crc", 32'(bus0.crc_out), 0);
`endif
    repeat (3) @(negedge clk);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle outputs",
                32'({bus0.word_ready, bus0.config_en, bus0.busy, bus0.done, bus0.config_clk}), 0);

    $display("[TB] short chain table vectors");
    for (int i = 0; i < 4; i++)
      applyStimulus(vecs[i].word, 1'b0, vecs[i].expSeq, vecs[i].expCrc, $sformatf("vec%0d", i));

    $display("[TB] short chain random words");
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom());
      q.delete();
      for (int k = 0; k < L1; k++) q.push_back(w[k]);
      applyStimulus(w, 1'b0, w, crcRef(q), $sformatf("rnd%0d", i));
    end

    $display("[TB] start pulsed while config_clk high");
    w = 8'hA6;
    q.delete();
    for (int k = 0; k < L1; k++) q.push_back(w[k]);
    applyStimulus(w, 1'b1, w, crcRef(q), "startInHi");

    $display("[TB] default chain back-to-back and random gaps");
    applyStimulusChain(0, -1, "chainB2B", aborted);
    applyStimulusChain(-1, -1, "chainRnd", aborted);

    $display("[TB] default chain with 20-cycle upstream stalls");
    applyStimulusChain(20, -1, "chainStall", aborted);

    $display("[TB] reset mid-load");
    applyStimulusChain(0, 100, "chainAbort", aborted);
    checkOutput("abort reached", 32'(aborted), 1);
    rst0_n = 1'b0;
    #1;
    checkOutput("midload reset outputs",
                32'({bus0.word_ready, bus0.config_in, bus0.config_clk, bus0.config_en, bus0.busy, bus0.done}), 0);
    bus0.word_valid = 1'b0;
    edgesHold = edges0;
    repeat (3) @(negedge clk);
    rst0_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("no edge after reset", 32'(edges0 - edgesHold), 0);
    checkOutput("idle after reset", 32'({bus0.busy, bus0.done, bus0.config_en}), 0);
    applyStimulusChain(-1, -1, "chainAfterReset", aborted);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
